// File: rtl/pb_red_offload_arb.sv
// Round-robin arbiter sharing one in-order reduction ALU between a narrow and a wide router port.
// An order FIFO of requester IDs steers ALU responses back to the port that issued them.
module pb_red_offload_arb #(
  parameter int unsigned WideWidth      = 512,
  parameter int unsigned NarrowWidth    = 64,
  parameter int unsigned OpWidth        = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [OpWidth-1:0]                  nar_req_op_i,
  input  logic [NarrowWidth-1:0]              nar_req_operand1_i,
  input  logic [NarrowWidth-1:0]              nar_req_operand2_i,
  input  logic                                nar_req_valid_i,
  output logic                                nar_req_ready_o,
  output logic [NarrowWidth-1:0]              nar_resp_result_o,
  output logic                                nar_resp_valid_o,
  input  logic                                nar_resp_ready_i,
  input  logic [OpWidth-1:0]                  wide_req_op_i,
  input  logic [WideWidth-1:0]                wide_req_operand1_i,
  input  logic [WideWidth-1:0]                wide_req_operand2_i,
  input  logic                                wide_req_valid_i,
  output logic                                wide_req_ready_o,
  output logic [WideWidth-1:0]                wide_resp_result_o,
  output logic                                wide_resp_valid_o,
  input  logic                                wide_resp_ready_i,
  output logic [OpWidth-1:0]                  alu_req_op_o,
  output logic [WideWidth-1:0]                alu_req_operand1_o,
  output logic [WideWidth-1:0]                alu_req_operand2_o,
  output logic                                alu_req_valid_o,
  input  logic                                alu_req_ready_i,
  input  logic [WideWidth-1:0]                alu_resp_result_i,
  input  logic                                alu_resp_valid_i,
  output logic                                alu_resp_ready_o,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o,
  output logic                                err_o
);

  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  logic                      prio_q, prio_d;
  logic                      lock_q, lock_d;
  logic                      lock_id_q, lock_id_d;
  logic                      err_q, err_d;
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic grant, gnt_valid, full, empty, head, push, pop;

  // Grant: held while a stalled request is pending, otherwise preferred requester first.
  always_comb begin
    grant = prio_q;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (!prio_q) begin
      grant = !nar_req_valid_i && wide_req_valid_i;
    end else begin
      grant = wide_req_valid_i || !nar_req_valid_i;
    end
  end

  assign full      = (cnt_q == CntW'(MaxOutstanding));
  assign empty     = (cnt_q == '0);
  assign gnt_valid = grant ? wide_req_valid_i : nar_req_valid_i;
  assign head      = fifo_q[rd_ptr_q];

  assign alu_req_valid_o    = !rst_i && gnt_valid && !full;
  assign nar_req_ready_o    = !rst_i && !grant && alu_req_ready_i && !full;
  assign wide_req_ready_o   = !rst_i && grant && alu_req_ready_i && !full;
  assign alu_req_op_o       = grant ? wide_req_op_i : nar_req_op_i;
  assign alu_req_operand1_o = grant ? wide_req_operand1_i : WideWidth'(nar_req_operand1_i);
  assign alu_req_operand2_o = grant ? wide_req_operand2_i : WideWidth'(nar_req_operand2_i);

  assign alu_resp_ready_o   = !rst_i && !empty && (head ? wide_resp_ready_i : nar_resp_ready_i);
  assign nar_resp_valid_o   = !rst_i && !empty && !head && alu_resp_valid_i;
  assign wide_resp_valid_o  = !rst_i && !empty && head && alu_resp_valid_i;
  assign nar_resp_result_o  = alu_resp_result_i[NarrowWidth-1:0];
  assign wide_resp_result_o = alu_resp_result_i;

  assign push = alu_req_valid_o && alu_req_ready_i;
  assign pop  = alu_resp_valid_i && alu_resp_ready_o;

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Next-state: order FIFO, occupancy, round-robin pointer, stall lock, sticky error.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    lock_d    = alu_req_valid_o && !alu_req_ready_i;
    lock_id_d = grant;
    err_d     = err_q || (alu_resp_valid_i && empty);
    if (push) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
      prio_d           = !grant;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_pb_red_offload_arb.sv
// Randomized and directed bench for pb_red_offload_arb against a queue-based transaction model.
module tb_pb_red_offload_arb;

  localparam int unsigned WW   = 512;
  localparam int unsigned NW   = 64;
  localparam int unsigned OW   = 4;
  localparam int unsigned MAXO = 4;

  typedef logic [WW-1:0] wv_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [OW-1:0] nar_req_op_i = '0, wide_req_op_i = '0;
  logic [NW-1:0] nar_req_operand1_i = '0, nar_req_operand2_i = '0;
  logic [WW-1:0] wide_req_operand1_i = '0, wide_req_operand2_i = '0;
  logic          nar_req_valid_i = 1'b0, wide_req_valid_i = 1'b0;
  logic          nar_resp_ready_i = 1'b0, wide_resp_ready_i = 1'b0;
  logic          alu_req_ready_i = 1'b0, alu_resp_valid_i = 1'b0;
  logic [WW-1:0] alu_resp_result_i = '0;
  logic          nar_req_ready_o, wide_req_ready_o, nar_resp_valid_o, wide_resp_valid_o;
  logic [NW-1:0] nar_resp_result_o;
  logic [WW-1:0] wide_resp_result_o, alu_req_operand1_o, alu_req_operand2_o;
  logic [OW-1:0] alu_req_op_o;
  logic          alu_req_valid_o, alu_resp_ready_o, err_o;
  logic [$clog2(MAXO):0] outstanding_o;

  pb_red_offload_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .nar_req_op_i(nar_req_op_i), .nar_req_operand1_i(nar_req_operand1_i),
    .nar_req_operand2_i(nar_req_operand2_i), .nar_req_valid_i(nar_req_valid_i),
    .nar_req_ready_o(nar_req_ready_o), .nar_resp_result_o(nar_resp_result_o),
    .nar_resp_valid_o(nar_resp_valid_o), .nar_resp_ready_i(nar_resp_ready_i),
    .wide_req_op_i(wide_req_op_i), .wide_req_operand1_i(wide_req_operand1_i),
    .wide_req_operand2_i(wide_req_operand2_i), .wide_req_valid_i(wide_req_valid_i),
    .wide_req_ready_o(wide_req_ready_o), .wide_resp_result_o(wide_resp_result_o),
    .wide_resp_valid_o(wide_resp_valid_o), .wide_resp_ready_i(wide_resp_ready_i),
    .alu_req_op_o(alu_req_op_o), .alu_req_operand1_o(alu_req_operand1_o),
    .alu_req_operand2_o(alu_req_operand2_o), .alu_req_valid_o(alu_req_valid_o),
    .alu_req_ready_i(alu_req_ready_i), .alu_resp_result_i(alu_resp_result_i),
    .alu_resp_valid_i(alu_resp_valid_i), .alu_resp_ready_o(alu_resp_ready_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model: in-flight ID queue, preferred requester, pending (stalled) request.
  int  m_q[$];
  int  m_prio    = 0;
  bit  m_pend    = 1'b0;
  int  m_pend_id = 0;
  bit  m_err     = 1'b0;
  bit  last_push = 1'b0;
  int  last_g    = 0;

  task automatic check(input string tag, input wv_t got, input wv_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wv_t rand_wide();
    wv_t v;
    for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit req_valid(input int id);
    return (id == 0) ? nar_req_valid_i : wide_req_valid_i;
  endfunction

  // One clock: inputs already driven; check outputs, step model on the edge.
  task automatic cycle();
    int  g;
    bit  full, exp_av, empty, exp_ar, push, pop;
    int  head;
    #1;
    if (m_pend) g = m_pend_id;
    else if (req_valid(m_prio)) g = m_prio;
    else if (req_valid(1 - m_prio)) g = 1 - m_prio;
    else g = m_prio;
    full   = (m_q.size() == MAXO);
    exp_av = req_valid(g) && !full;
    empty  = (m_q.size() == 0);
    head   = empty ? 0 : m_q[0];
    exp_ar = !empty && ((head == 0) ? nar_resp_ready_i : wide_resp_ready_i);

    check("alu_req_valid", wv_t'(alu_req_valid_o), wv_t'(exp_av));
    check("nar_req_ready", wv_t'(nar_req_ready_o), wv_t'(g == 0 && alu_req_ready_i && !full));
    check("wide_req_ready", wv_t'(wide_req_ready_o), wv_t'(g == 1 && alu_req_ready_i && !full));
    if (exp_av) begin
      check("alu_op", wv_t'(alu_req_op_o), wv_t'((g == 0) ? nar_req_op_i : wide_req_op_i));
      check("alu_opnd1", alu_req_operand1_o,
            (g == 0) ? wv_t'(nar_req_operand1_i) : wide_req_operand1_i);
      check("alu_opnd2", alu_req_operand2_o,
            (g == 0) ? wv_t'(nar_req_operand2_i) : wide_req_operand2_i);
    end
    check("nar_resp_valid", wv_t'(nar_resp_valid_o), wv_t'(!empty && head == 0 && alu_resp_valid_i));
    check("wide_resp_valid", wv_t'(wide_resp_valid_o), wv_t'(!empty && head == 1 && alu_resp_valid_i));
    check("alu_resp_ready", wv_t'(alu_resp_ready_o), wv_t'(exp_ar));
    if (nar_resp_valid_o)
      check("nar_result", wv_t'(nar_resp_result_o), wv_t'(alu_resp_result_i % (wv_t'(1) << NW)));
    if (wide_resp_valid_o) check("wide_result", wide_resp_result_o, alu_resp_result_i);
    check("outstanding", wv_t'(outstanding_o), wv_t'(m_q.size()));
    check("err", wv_t'(err_o), wv_t'(m_err));

    push = exp_av && alu_req_ready_i;
    pop  = alu_resp_valid_i && exp_ar;
    @(posedge clk_i);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(g);
      m_prio = 1 - g;
    end
    m_pend    = exp_av && !alu_req_ready_i;
    m_pend_id = g;
    if (alu_resp_valid_i && empty) m_err = 1'b1;
    last_push = push;
    last_g    = g;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    nar_req_valid_i   = 1'b0;
    wide_req_valid_i  = 1'b0;
    alu_req_ready_i   = 1'b0;
    alu_resp_valid_i  = 1'b0;
    nar_resp_ready_i  = 1'b0;
    wide_resp_ready_i = 1'b0;
  endtask

  // Reset asserted between edges: state must clear without a clock.
  task automatic do_reset();
    rst_i            = 1'b1;
    nar_req_valid_i  = 1'b1;
    wide_req_valid_i = 1'b1;
    alu_req_ready_i  = 1'b1;
    alu_resp_valid_i = 1'b1;
    #1;
    check("rst_outstanding", wv_t'(outstanding_o), wv_t'(0));
    check("rst_err", wv_t'(err_o), wv_t'(0));
    check("rst_alu_valid", wv_t'(alu_req_valid_o), wv_t'(0));
    check("rst_readies", wv_t'({nar_req_ready_o, wide_req_ready_o, alu_resp_ready_o}), wv_t'(0));
    check("rst_resp_valid", wv_t'({nar_resp_valid_o, wide_resp_valid_o}), wv_t'(0));
    idle_inputs();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_q.delete();
    m_prio = 0; m_pend = 1'b0; m_err = 1'b0; last_push = 1'b0;
  endtask

  task automatic new_nar();
    nar_req_op_i       = OW'($urandom);
    nar_req_operand1_i = {$urandom, $urandom};
    nar_req_operand2_i = {$urandom, $urandom};
  endtask

  task automatic new_wide();
    wide_req_op_i       = OW'($urandom);
    wide_req_operand1_i = rand_wide();
    wide_req_operand2_i = rand_wide();
  endtask

  initial begin
    wv_t w_hold;
    int  guard;
    @(negedge clk_i);
    do_reset();

    // Both requesters valid after reset: narrow first, then wide.
    new_nar(); new_wide();
    nar_req_valid_i = 1'b1; wide_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    #1 check("d025_first_narrow", wv_t'(alu_req_operand1_o), wv_t'(nar_req_operand1_i));
    cycle();
    check("d025_cnt1", wv_t'(outstanding_o), wv_t'(1));
    new_nar();
    #1 check("d025_then_wide", alu_req_operand1_o, wide_req_operand1_i);
    cycle();
    check("d025_cnt2", wv_t'(outstanding_o), wv_t'(2));

    // Wide stalled three cycles; narrow arriving mid-stall must not steal the grant.
    nar_req_valid_i = 1'b0; new_wide(); w_hold = wide_req_operand1_i; alu_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nar_req_valid_i = 1'b1;
      #1 check("d026_stable", alu_req_operand1_o, w_hold);
      cycle();
    end
    alu_req_ready_i = 1'b1;
    cycle();
    check("d026_cnt3", wv_t'(outstanding_o), wv_t'(3));

    // Fill to MaxOutstanding, then a response with a new request in the same cycle stays blocked.
    wide_req_valid_i = 1'b0;
    cycle();
    check("d027_full", wv_t'(outstanding_o), wv_t'(MAXO));
    new_nar(); wide_req_valid_i = 1'b1;
    alu_resp_valid_i = 1'b1; nar_resp_ready_i = 1'b1; wide_resp_ready_i = 1'b1;
    alu_resp_result_i = rand_wide();
    cycle();
    check("d027_cnt_after_pop", wv_t'(outstanding_o), wv_t'(MAXO - 1));
    nar_req_valid_i = 1'b0; wide_req_valid_i = 1'b0;
    guard = 0;
    while (m_q.size() > 0 && guard < 20) begin
      alu_resp_result_i = rand_wide();
      cycle();
      guard++;
    end
    check("drain_done", wv_t'(m_q.size()), wv_t'(0));
    idle_inputs();

    // Narrow then wide op; results come back in order, narrow truncated.
    do_reset();
    new_nar(); nar_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    cycle();
    nar_req_valid_i = 1'b0; new_wide(); wide_req_valid_i = 1'b1;
    cycle();
    wide_req_valid_i = 1'b0;
    alu_resp_valid_i = 1'b1; nar_resp_ready_i = 1'b1; wide_resp_ready_i = 1'b1;
    alu_resp_result_i = {64{8'hA5}};
    #1 check("d028_nar_result", wv_t'(nar_resp_result_o), wv_t'(64'hA5A5A5A5A5A5A5A5));
    cycle();
    alu_resp_result_i = {64{8'h3C}};
    #1 check("d028_wide_result", wide_resp_result_o, {64{8'h3C}});
    cycle();

    // Spurious response while empty raises a sticky error.
    cycle();
    check("d029_err_set", wv_t'(err_o), wv_t'(1));
    alu_resp_valid_i = 1'b0;
    cycle(); cycle();
    check("d029_err_sticky", wv_t'(err_o), wv_t'(1));

    // Two outstanding (wide then narrow, so wide is preferred), then async reset.
    new_wide(); wide_req_valid_i = 1'b1;
    cycle();
    wide_req_valid_i = 1'b0; new_nar(); nar_req_valid_i = 1'b1;
    cycle();
    check("d030_cnt_before", wv_t'(outstanding_o), wv_t'(2));
    do_reset();
    new_nar(); new_wide();
    nar_req_valid_i = 1'b1; wide_req_valid_i = 1'b1; alu_req_ready_i = 1'b1;
    #1 check("d030_prio_narrow", wv_t'(alu_req_op_o), wv_t'(nar_req_op_i));
    cycle();
    idle_inputs();
    guard = 0;
    while (m_q.size() > 0 && guard < 20) begin
      alu_resp_valid_i = 1'b1; nar_resp_ready_i = 1'b1; wide_resp_ready_i = 1'b1;
      alu_resp_result_i = rand_wide();
      cycle();
      guard++;
    end
    idle_inputs();

    // Random traffic: requesters hold valid and payload until accepted.
    for (int c = 0; c < 1500; c++) begin
      if (!(nar_req_valid_i && !(last_push && last_g == 0))) begin
        nar_req_valid_i = ($urandom_range(0, 9) < 6);
        new_nar();
      end
      if (!(wide_req_valid_i && !(last_push && last_g == 1))) begin
        wide_req_valid_i = ($urandom_range(0, 9) < 6);
        new_wide();
      end
      alu_req_ready_i   = ($urandom_range(0, 9) < 7);
      alu_resp_valid_i  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      nar_resp_ready_i  = ($urandom_range(0, 9) < 7);
      wide_resp_ready_i = ($urandom_range(0, 9) < 7);
      alu_resp_result_i = rand_wide();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
